// File: rtl/egress_frame_writer_pkg.sv
// Shared types for the egress frame writer: FSM states, fabric header layout
// and the pointer-FIFO descriptor format.
package egress_frame_writer_pkg;

  localparam int ERR_BIT = 16;
  localparam int SRC_MSB = 15;
  localparam int SRC_LSB = 12;
  localparam int LEN_W   = 12;
  localparam int DESC_W  = 17;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR1 = 3'd1,
    ST_HDR2 = 3'd2,
    ST_DATA = 3'd3,
    ST_TAIL = 3'd4,
    ST_SKIP = 3'd5
  } efw_state_e;

  // Second header byte: source port and upper length nibble.
  typedef struct packed {
    logic [3:0] src;
    logic [3:0] len_hi;
  } fab_hdr1_t;

  function automatic logic [DESC_W-1:0] make_desc(input logic err,
                                                  input logic [3:0] src,
                                                  input logic [LEN_W-1:0] len);
    logic [DESC_W-1:0] d;
    d                  = {DESC_W{1'b0}};
    d[ERR_BIT]         = err;
    d[SRC_MSB:SRC_LSB] = src;
    d[LEN_W-1:0]       = len;
    return d;
  endfunction

endpackage

// File: rtl/egress_frame_writer_if.sv
// Fabric record stream plus the data/pointer FIFO write ports of one egress port.
interface egress_frame_writer_if;
  logic        sof;
  logic        dv;
  logic [7:0]  data;
  logic        bp;
  logic        dfifo_wr;
  logic [7:0]  dfifo_din;
  logic [11:0] dfifo_free;
  logic        pfifo_wr;
  logic [16:0] pfifo_din;
  logic        pfifo_full;

  modport master (
    output sof, dv, data, dfifo_free, pfifo_full,
    input  bp, dfifo_wr, dfifo_din, pfifo_wr, pfifo_din
  );

  modport slave (
    input  sof, dv, data, dfifo_free, pfifo_full,
    output bp, dfifo_wr, dfifo_din, pfifo_wr, pfifo_din
  );
endinterface

// File: rtl/egress_frame_writer_sat_counter16.sv
// 16-bit statistics counter that sticks at all-ones; clear beats increment.
module sat_counter16 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] value
);

  // Saturating count with synchronous clear priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= 16'h0000;
    end else if (clr) begin
      value <= 16'h0000;
    end else if (inc && (value != 16'hFFFF)) begin
      value <= value + 16'd1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/egress_frame_writer.sv
// Egress sink for the fabric record stream: claims records addressed to
// PORT_ID, strips the 3-byte header, writes payload and one descriptor per frame.
module egress_frame_writer
  import egress_frame_writer_pkg::*;
#(
  parameter int PORT_ID   = 0,
  parameter int MAX_LEN   = 1536,
  parameter int BP_THRESH = 1600
) (
  input  logic                 clk,
  input  logic                 rstn,
  egress_frame_writer_if.slave fab,
  input  logic                 stat_clr,
  output logic [15:0]          frm_cnt,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          err_cnt
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = 12'(MAX_LEN);
  localparam logic [11:0]      BP_C      = 12'(BP_THRESH);

  efw_state_e        state_r;
  logic [3:0]        src_r;
  logic [3:0]        len_hi_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt_r;
  logic              bp_r;
  logic              dfifo_wr_r;
  logic [7:0]        dfifo_din_r;
  logic              pfifo_wr_r;
  logic [DESC_W-1:0] pfifo_din_r;
  logic              frm_inc_r;
  logic              drop_inc_r;
  logic              err_inc_r;

  logic              start_s;
  logic              accept_s;
  logic [LEN_W-1:0]  len_s;
  logic [LEN_W-1:0]  cnt_nxt_s;
  fab_hdr1_t         hdr1_s;

  assign start_s   = fab.sof & fab.dv;
  assign hdr1_s    = fab.data;
  assign len_s     = {len_hi_r, fab.data};
  assign cnt_nxt_s = cnt_r + 12'd1;
  // Space is reserved only here; the reader can only add free space later.
  assign accept_s  = (len_s != 12'd0) && (len_s <= MAX_LEN_C) &&
                     (fab.dfifo_free >= len_s) && !fab.pfifo_full;

  // A sof byte always starts a new record, whatever state we were in.
  function automatic efw_state_e byte0_next(input logic [7:0] b);
    return b[PORT_ID] ? ST_HDR1 : ST_SKIP;
  endfunction

  // Record FSM with header latch and registered FIFO write path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      src_r       <= 4'd0;
      len_hi_r    <= 4'd0;
      len_r       <= 12'd0;
      cnt_r       <= 12'd0;
      bp_r        <= 1'b0;
      dfifo_wr_r  <= 1'b0;
      dfifo_din_r <= 8'd0;
      pfifo_wr_r  <= 1'b0;
      pfifo_din_r <= 17'd0;
      frm_inc_r   <= 1'b0;
      drop_inc_r  <= 1'b0;
      err_inc_r   <= 1'b0;
    end else begin
      dfifo_wr_r <= 1'b0;
      pfifo_wr_r <= 1'b0;
      frm_inc_r  <= 1'b0;
      drop_inc_r <= 1'b0;
      err_inc_r  <= 1'b0;
      bp_r       <= (fab.dfifo_free < BP_C) || fab.pfifo_full;
      case (state_r)
        ST_IDLE: begin
          if (start_s) state_r <= byte0_next(fab.data);
          else         state_r <= ST_IDLE;
        end
        ST_HDR1: begin
          if (start_s) begin
            drop_inc_r <= 1'b1;
            state_r    <= byte0_next(fab.data);
          end else if (!fab.dv) begin
            drop_inc_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else begin
            src_r    <= hdr1_s.src;
            len_hi_r <= hdr1_s.len_hi;
            state_r  <= ST_HDR2;
          end
        end
        ST_HDR2: begin
          if (start_s) begin
            drop_inc_r <= 1'b1;
            state_r    <= byte0_next(fab.data);
          end else if (!fab.dv) begin
            drop_inc_r <= 1'b1;
            state_r    <= ST_IDLE;
          end else if (accept_s) begin
            len_r   <= len_s;
            cnt_r   <= 12'd0;
            state_r <= ST_DATA;
          end else begin
            drop_inc_r <= 1'b1;
            state_r    <= ST_SKIP;
          end
        end
        ST_DATA: begin
          if (start_s || !fab.dv) begin
            // Truncated frame: commit what was written, flagged as errored.
            pfifo_wr_r  <= 1'b1;
            pfifo_din_r <= make_desc(1'b1, src_r, cnt_r);
            err_inc_r   <= 1'b1;
            state_r     <= start_s ? byte0_next(fab.data) : ST_IDLE;
          end else begin
            dfifo_wr_r  <= 1'b1;
            dfifo_din_r <= fab.data;
            cnt_r       <= cnt_nxt_s;
            if (cnt_nxt_s == len_r) begin
              pfifo_wr_r  <= 1'b1;
              pfifo_din_r <= make_desc(1'b0, src_r, len_r);
              frm_inc_r   <= 1'b1;
              state_r     <= ST_TAIL;
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_TAIL, ST_SKIP: begin
          if (start_s)      state_r <= byte0_next(fab.data);
          else if (!fab.dv) state_r <= ST_IDLE;
          else              state_r <= state_r;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign fab.bp        = bp_r;
  assign fab.dfifo_wr  = dfifo_wr_r;
  assign fab.dfifo_din = dfifo_din_r;
  assign fab.pfifo_wr  = pfifo_wr_r;
  assign fab.pfifo_din = pfifo_din_r;

  sat_counter16 u_frm_cnt  (.clk(clk), .rstn(rstn), .inc(frm_inc_r),  .clr(stat_clr), .value(frm_cnt));
  sat_counter16 u_drop_cnt (.clk(clk), .rstn(rstn), .inc(drop_inc_r), .clr(stat_clr), .value(drop_cnt));
  sat_counter16 u_err_cnt  (.clk(clk), .rstn(rstn), .inc(err_inc_r),  .clr(stat_clr), .value(err_cnt));

endmodule

// File: tb/tb_egress_frame_writer.sv
// Record-level scoreboard bench for egress_frame_writer (PORT_ID=1): stimulus and
// expected FIFO writes are laid out per clock tick from the record rules.
module tb_egress_frame_writer;

  localparam int TB_PORT = 1;
  localparam int MAXT    = 16384;

  logic        clk;
  logic        rstn;
  logic        stat_clr;
  logic [15:0] frm_cnt, drop_cnt, err_cnt;

  egress_frame_writer_if fab();

  egress_frame_writer #(.PORT_ID(TB_PORT), .MAX_LEN(1536), .BP_THRESH(1600)) dut (
    .clk(clk), .rstn(rstn), .fab(fab), .stat_clr(stat_clr),
    .frm_cnt(frm_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-tick stimulus and expected outputs (expected index = input tick + 1).
  bit        s_sof [MAXT];
  bit        s_dv  [MAXT];
  bit [7:0]  s_data[MAXT];
  bit [11:0] s_free[MAXT];
  bit        s_full[MAXT];
  bit        exp_dwr [MAXT];
  bit [7:0]  exp_ddin[MAXT];
  bit        exp_pwr [MAXT];
  bit [16:0] exp_pdin[MAXT];

  int tick = 0;
  int wp;
  int n_cmp = 0;
  int n_fail = 0;
  int m_frm, m_drop, m_err;
  bit chk_en = 1'b0;
  logic [11:0] smp_free;
  logic        smp_full;
  logic [16:0] obs_desc[$];

  always @(posedge clk) begin
    tick     <= tick + 1;
    smp_free <= fab.dfifo_free;
    smp_full <= fab.pfifo_full;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s tick=%0d got=%0h expected=%0h", name, tick, act, exp_v);
    end
  endtask

  // Per-cycle compare against the record-level expectations.
  always @(negedge clk) begin
    if (chk_en && tick < MAXT) begin
      chk("dfifo_wr", 32'(fab.dfifo_wr), 32'(exp_dwr[tick]));
      if (exp_dwr[tick] && fab.dfifo_wr) chk("dfifo_din", 32'(fab.dfifo_din), 32'(exp_ddin[tick]));
      chk("pfifo_wr", 32'(fab.pfifo_wr), 32'(exp_pwr[tick]));
      if (exp_pwr[tick] && fab.pfifo_wr) chk("pfifo_din", 32'(fab.pfifo_din), 32'(exp_pdin[tick]));
      chk("bp", 32'(fab.bp), 32'((smp_free < 12'd1600) || smp_full));
      if (fab.pfifo_wr) obs_desc.push_back(fab.pfifo_din);
    end
  end

  // Lay out one record and predict its outcome from the record rules.
  task automatic add_rec(input bit [3:0] map, input bit [3:0] src, input int len,
                         input int nbytes, input int gap, input bit [11:0] free, input bit full);
    int st, p;
    bit [7:0] b;
    bit [11:0] l12;
    if (wp + nbytes + gap + 8 >= MAXT) return;
    l12 = 12'(len);
    st  = wp;
    for (int i = 0; i < nbytes + gap; i++) begin
      case (i)
        0:       b = {4'b0000, map};
        1:       b = {src, l12[11:8]};
        2:       b = l12[7:0];
        default: b = 8'($urandom_range(0, 255));
      endcase
      s_sof[st+i]  = (i == 0);
      s_dv[st+i]   = (i < nbytes);
      s_data[st+i] = b;
      s_free[st+i] = free;
      s_full[st+i] = full;
    end
    wp = st + nbytes + gap;
    if (map[TB_PORT]) begin
      if (nbytes < 3) m_drop++;
      else if (len == 0 || len > 1536 || int'(free) < len || full) m_drop++;
      else begin
        p = (nbytes - 3 < len) ? nbytes - 3 : len;
        for (int k = 0; k < p; k++) begin
          exp_dwr[st+4+k]  = 1'b1;
          exp_ddin[st+4+k] = s_data[st+3+k];
        end
        if (p == len) begin
          exp_pwr[st+3+len]  = 1'b1;
          exp_pdin[st+3+len] = {1'b0, src, l12};
          m_frm++;
        end else begin
          exp_pwr[st+nbytes+1]  = 1'b1;
          exp_pdin[st+nbytes+1] = {1'b1, src, 12'(p)};
          m_err++;
        end
      end
    end
  endtask

  task automatic add_idle(input int n, input bit [11:0] free, input bit full);
    for (int i = 0; i < n; i++) begin
      s_sof[wp] = 1'b0; s_dv[wp] = 1'b0; s_data[wp] = 8'h00;
      s_free[wp] = free; s_full[wp] = full;
      wp++;
    end
  endtask

  task automatic run_seg();
    chk_en = 1'b1;
    do begin
      @(negedge clk);
      fab.sof = s_sof[tick]; fab.dv = s_dv[tick]; fab.data = s_data[tick];
      fab.dfifo_free = s_free[tick]; fab.pfifo_full = s_full[tick];
    end while (tick < wp - 1);
    @(negedge clk);
    @(posedge clk); #1;
    chk_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bp"}, 32'(fab.bp), 32'd0);
    chk({tag, "_dfifo_wr"}, 32'(fab.dfifo_wr), 32'd0);
    chk({tag, "_dfifo_din"}, 32'(fab.dfifo_din), 32'd0);
    chk({tag, "_pfifo_wr"}, 32'(fab.pfifo_wr), 32'd0);
    chk({tag, "_pfifo_din"}, 32'(fab.pfifo_din), 32'd0);
    chk({tag, "_frm_cnt"}, 32'(frm_cnt), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(m_frm));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    rstn = 1'b0; stat_clr = 1'b0;
    fab.sof = 1'b0; fab.dv = 1'b0; fab.data = 8'h00;
    fab.dfifo_free = 12'd2000; fab.pfifo_full = 1'b0;
    m_frm = 0; m_drop = 0; m_err = 0;
    repeat (3) @(posedge clk); #1;
    check_zero("reset");
    @(negedge clk); rstn = 1'b1;

    // Directed records from the plan plus length/space/header boundaries.
    @(posedge clk); #1;
    wp = tick;
    obs_desc.delete();
    add_rec(4'b0010, 4'd2, 64, 73, 3, 12'd2000, 1'b0);
    add_rec(4'b0100, 4'd2, 64, 67, 2, 12'd2000, 1'b0);
    add_rec(4'b0010, 4'd6, 60, 63, 2, 12'd50, 1'b0);
    add_rec(4'b0010, 4'd5, 60, 63, 2, 12'd2000, 1'b0);
    add_rec(4'b0010, 4'd3, 100, 23, 3, 12'd2000, 1'b0);
    add_rec(4'b0010, 4'd7, 80, 13, 0, 12'd2000, 1'b0);
    add_rec(4'b0010, 4'd1, 64, 67, 3, 12'd2000, 1'b0);
    add_rec(4'b0011, 4'd9, 5, 2, 0, 12'd2000, 1'b0);
    add_rec(4'b0010, 4'd9, 5, 1, 2, 12'd2000, 1'b0);
    add_rec(4'b1010, 4'd4, 0, 5, 2, 12'd2000, 1'b0);
    add_rec(4'b0010, 4'd4, 1537, 10, 2, 12'd4095, 1'b0);
    add_rec(4'b0010, 4'd4, 10, 15, 2, 12'd2000, 1'b1);
    add_rec(4'b0010, 4'd8, 1536, 1539, 3, 12'd1536, 1'b0);
    add_rec(4'b0010, 4'd8, 1, 4, 3, 12'd1, 1'b0);
    add_idle(4, 12'd1599, 1'b0);
    add_idle(4, 12'd1600, 1'b0);
    add_idle(3, 12'd1600, 1'b1);
    add_idle(4, 12'd3000, 1'b0);
    run_seg();
    chk("dir_ndesc", 32'(obs_desc.size()), 32'd7);
    if (obs_desc.size() == 7) begin
      chk("dir_desc_clean64", 32'(obs_desc[0]), 32'h0_2040);
      chk("dir_desc_trunc20", 32'(obs_desc[2]), 32'h1_3014);
      chk("dir_desc_sof10", 32'(obs_desc[3]), 32'h1_700A);
      chk("dir_desc_after_sof", 32'(obs_desc[4]), 32'h0_1040);
      chk("dir_desc_max", 32'(obs_desc[5]), 32'h0_8600);
    end
    chk("dir_frm_cnt", 32'(frm_cnt), 32'd5);
    chk("dir_drop_cnt", 32'(drop_cnt), 32'd6);
    chk("dir_err_cnt", 32'(err_cnt), 32'd2);
    check_counts("dir_model");

    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    @(posedge clk); #1;
    chk("clr_frm_cnt", 32'(frm_cnt), 32'd0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    m_frm = 0; m_drop = 0; m_err = 0;

    // Randomized records: mixed addressing, lengths, space, truncation, sof aborts.
    wp = tick;
    for (int r = 0; r < 60; r++) begin
      int len, nb, gp, sel;
      bit [11:0] fr;
      bit fl;
      sel = $urandom_range(0, 99);
      if (sel < 5)       len = 0;
      else if (sel < 10) len = $urandom_range(1537, 1700);
      else if (sel < 14) len = $urandom_range(1200, 1536);
      else               len = $urandom_range(1, 160);
      fr = ($urandom_range(0, 9) < 7) ? 12'($urandom_range(1000, 4095)) : 12'($urandom_range(0, 300));
      fl = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 99);
      if (len > 1536)                nb = 3 + $urandom_range(0, 20);
      else if (sel < 60 || len == 0) nb = 3 + len + $urandom_range(0, 5);
      else                           nb = $urandom_range(1, 2 + len);
      gp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      if (r == 59) gp = 6;
      add_rec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), len, nb, gp, fr, fl);
    end
    add_idle(6, 12'd3000, 1'b0);
    run_seg();
    check_counts("rand");

    // Reset pulsed while a frame is mid-payload.
    wp = tick;
    add_rec(4'b0010, 4'd4, 50, 40, 0, 12'd2000, 1'b0);
    run_seg();
    @(negedge clk); rstn = 1'b0;
    #1;
    check_zero("midframe_reset");
    fab.sof = 1'b0; fab.dv = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_frm = 0; m_drop = 0; m_err = 0;
    @(posedge clk); #1;
    wp = tick;
    obs_desc.delete();
    add_rec(4'b0010, 4'd11, 30, 35, 4, 12'd2000, 1'b0);
    add_idle(4, 12'd2000, 1'b0);
    run_seg();
    chk("post_reset_ndesc", 32'(obs_desc.size()), 32'd1);
    if (obs_desc.size() == 1) chk("post_reset_desc", 32'(obs_desc[0]), 32'h0_B01E);
    chk("post_reset_frm_cnt", 32'(frm_cnt), 32'd1);
    check_counts("post_reset_model");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
